psum_drain: RTL

//  Read-side engine for the per-row psum memory banks; the controller writes these banks

---
 rtl/psum_drain_pkg.sv | 17 +
 rtl/psum_drain_line_buf.sv | 68 ++++++
 rtl/psum_drain.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/psum_drain_pkg.sv
// Shared types and defaults for the psum drain engine.
package psum_drain_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StShift,
        StFin
    } state_e;

    localparam int unsigned PSUM_W_DEF    = 48;
    localparam int unsigned ADDR_STEP_DEF = 8;

    typedef logic [PSUM_W_DEF-1:0] psum_t;

endpackage

// File: rtl/psum_drain_line_buf.sv
// Line buffer: parallel load of one psum line, serial output row 0..ROWS-1 with hold.
module psum_line_buf
    import psum_drain_pkg::*;
#(
    parameter int unsigned ROWS = 16,
    parameter int unsigned W    = PSUM_W_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      load_i,
    input  logic [ROWS-1:0][W-1:0]    load_data_i,
    input  logic                      load_last_i,
    input  logic                      pop_i,
    output logic                      valid_o,
    output logic [W-1:0]              data_o,
    output logic [$clog2(ROWS)-1:0]   row_o,
    output logic                      row_end_o,
    output logic                      last_o
);

    localparam int unsigned RowW = $clog2(ROWS);

    logic [ROWS-1:0][W-1:0] line_q, line_d;
    logic [RowW-1:0]        row_q, row_d;
    logic                   full_q, full_d;
    logic                   last_q, last_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= '0;
            row_q  <= '0;
            full_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            line_q <= line_d;
            row_q  <= row_d;
            full_q <= full_d;
            last_q <= last_d;
        end
    end

    always_comb begin
        line_d = line_q;
        row_d  = row_q;
        full_d = full_q;
        last_d = last_q;
        if (load_i) begin
            line_d = load_data_i;
            row_d  = '0;
            full_d = 1'b1;
            last_d = load_last_i;
        end else if (pop_i && full_q) begin
            if (row_end_o) begin
                row_d  = '0;
                full_d = 1'b0;
            end else begin
                row_d = row_q + 1'b1;
            end
        end
    end

    assign valid_o   = full_q;
    assign data_o    = line_q[row_q];
    assign row_o     = row_q;
    assign row_end_o = (row_q == RowW'(ROWS - 1));
    assign last_o    = full_q && row_end_o && last_q;

endmodule

// File: rtl/psum_drain.sv
// Drains ROWS psum banks onto a valid/ready stream, address-major, row 0..ROWS-1.
// Optional PSUM_DRAIN_PREFETCH_EN: ping-pong line buffers, next line fetched during drain.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int unsigned ROWS      = 16,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned ADDR_STEP = ADDR_STEP_DEF,
    parameter int unsigned PSUM_W    = PSUM_W_DEF,
    parameter int unsigned MEM_LAT   = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [ADDR_W-1:0]            base_addr_i,
    input  logic [15:0]                  count_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [ROWS-1:0][ADDR_W-1:0]  mem_addr_o,
    input  logic [ROWS-1:0][63:0]        mem_rdata_i,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic [PSUM_W-1:0]            m_data_o,
    output logic [$clog2(ROWS)-1:0]      m_row_o,
    output logic                         m_last_o
);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       cur_addr_q, cur_addr_d, hold_addr_q;
    logic [15:0]             words_left_q, words_left_d;
    logic [MEM_LAT-1:0]      lat_q, last_sr_q;
    logic                    accept, fetch, rd_done, rd_last, hs, row_end;
    logic [ROWS-1:0][PSUM_W-1:0] rd_psum;
    logic                    unused_rdata_hi;

    assign accept  = (state_q == StIdle) && start_i;
    assign rd_done = lat_q[MEM_LAT-1];
    assign rd_last = last_sr_q[MEM_LAT-1];
    assign hs      = m_valid_o && m_ready_i;

    // The address is only meaningful in the fetch cycle; it holds otherwise.
    assign mem_addr_o = {ROWS{fetch ? cur_addr_q : hold_addr_q}};

    always_comb begin
        unused_rdata_hi = 1'b0;
        for (int r = 0; r < int'(ROWS); r++) begin
            rd_psum[r]      = mem_rdata_i[r][PSUM_W-1:0];
            unused_rdata_hi = unused_rdata_hi ^ (^mem_rdata_i[r][63:PSUM_W]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // The latency shift registers track in-flight reads and whether each is the final line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_addr_q   <= '0;
            hold_addr_q  <= '0;
            words_left_q <= '0;
            lat_q        <= '0;
            last_sr_q    <= '0;
        end else begin
            cur_addr_q   <= cur_addr_d;
            words_left_q <= words_left_d;
            lat_q        <= MEM_LAT'({lat_q, fetch});
            last_sr_q    <= MEM_LAT'({last_sr_q, fetch && (words_left_q == 16'd1)});
            if (fetch) begin
                hold_addr_q <= cur_addr_q;
            end
        end
    end

    always_comb begin
        cur_addr_d   = cur_addr_q;
        words_left_d = words_left_q;
        if (accept) begin
            cur_addr_d   = base_addr_i;
            words_left_d = count_i;
        end else if (fetch) begin
            cur_addr_d   = cur_addr_q + ADDR_W'(ADDR_STEP);
            words_left_d = words_left_q - 16'd1;
        end
    end

`ifdef PSUM_DRAIN_PREFETCH_EN
    logic                    wr_sel_q, rd_sel_q;
    logic                    v0, v1, e0, e1, l0, l1, pf_ok;
    logic [PSUM_W-1:0]       d0, d1;
    logic [$clog2(ROWS)-1:0] r0, r1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            if (rd_done) wr_sel_q <= ~wr_sel_q;
            if (hs && row_end) rd_sel_q <= ~rd_sel_q;
        end
    end

    // One read in flight at most, and only when a buffer is free to receive it.
    assign pf_ok = (words_left_q != 16'd0) && (lat_q == '0) && !(v0 && v1);

    psum_line_buf #(.ROWS(ROWS), .W(PSUM_W)) u_buf0 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (rd_done && !wr_sel_q),
        .load_data_i (rd_psum),
        .load_last_i (rd_last),
        .pop_i       (hs && !rd_sel_q),
        .valid_o     (v0),
        .data_o      (d0),
        .row_o       (r0),
        .row_end_o   (e0),
        .last_o      (l0)
    );

    psum_line_buf #(.ROWS(ROWS), .W(PSUM_W)) u_buf1 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (rd_done && wr_sel_q),
        .load_data_i (rd_psum),
        .load_last_i (rd_last),
        .pop_i       (hs && rd_sel_q),
        .valid_o     (v1),
        .data_o      (d1),
        .row_o       (r1),
        .row_end_o   (e1),
        .last_o      (l1)
    );

    assign m_valid_o = rd_sel_q ? v1 : v0;
    assign m_data_o  = rd_sel_q ? d1 : d0;
    assign m_row_o   = rd_sel_q ? r1 : r0;
    assign row_end   = rd_sel_q ? e1 : e0;
    assign m_last_o  = rd_sel_q ? l1 : l0;
`else
    psum_line_buf #(.ROWS(ROWS), .W(PSUM_W)) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (rd_done),
        .load_data_i (rd_psum),
        .load_last_i (rd_last),
        .pop_i       (hs),
        .valid_o     (m_valid_o),
        .data_o      (m_data_o),
        .row_o       (m_row_o),
        .row_end_o   (row_end),
        .last_o      (m_last_o)
    );
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = (count_i == 16'd0) ? StFin : StFetch;
            StFetch: state_d = StWait;
            StWait:  if (rd_done) state_d = StShift;
`ifdef PSUM_DRAIN_PREFETCH_EN
            StShift: if (hs && m_last_o) state_d = StFin;
`else
            StShift: if (hs && row_end) state_d = m_last_o ? StFin : StFetch;
`endif
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o = accept;
        done_o = 1'b0;
        fetch  = 1'b0;
        unique case (state_q)
            StIdle:  ;
            StFetch: begin
                busy_o = 1'b1;
                fetch  = 1'b1;
            end
            StWait:  busy_o = 1'b1;
            StShift: begin
                busy_o = 1'b1;
`ifdef PSUM_DRAIN_PREFETCH_EN
                fetch  = pf_ok;
`endif
            end
            StFin:   done_o = 1'b1;
            default: ;
        endcase
    end

endmodule
